combo_sweep_ctrl: RTL and testbench

//  Sequencer for the 5-input combinational `combo` block: on `start`, drives {a,b,c,d,e} through all 2^N_IN vectors in order.

---
 rtl/combo_pkg.sv | 14 +
 rtl/combo_settle_timer.sv | 25 ++
 rtl/combo_sweep_ctrl.sv | 137 +++++++++++++
 tb/tb_combo_sweep_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/combo_pkg.sv
// rtl/combo_pkg.sv - shared state encoding and sizing for the combo sweep controller
package combo_pkg;

  localparam int N_IN_DEF = 5;
  localparam int TBL_W    = 1 << N_IN_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/combo_settle_timer.sv
// rtl/combo_settle_timer.sv - per-vector settle down-counter
// expire is asserted in the last held cycle so the FSM leaves SETTLE on that edge.
module combo_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  output logic       expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign expire = (r_cnt == 4'd1);

endmodule

// File: rtl/combo_sweep_ctrl.sv
// rtl/combo_sweep_ctrl.sv - sweeps combo inputs, captures z into a truth table
// and compares it against a caller-supplied golden table.
module combo_sweep_ctrl
  import combo_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   z_in,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          mismatch_count,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail
);

  sweep_state_t r_state;
  sweep_state_t w_next;

  logic [N_IN-1:0]        r_idx;
  logic [(1<<N_IN)-1:0]   r_table;
  logic [N_IN:0]          r_mis;
  logic                   r_fail_valid;
  logic [N_IN-1:0]        r_first_fail;

  logic w_load;
  logic w_clear;
  logic w_capture;
  logic w_abort;
  logic w_expire;
  logic w_last;

  assign w_last = (r_idx == {N_IN{1'b1}});

  combo_settle_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .value  (4'(SETTLE)),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks start/capture only while busy; in IDLE/DONE it is never looked at
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next  = ST_SETTLE;
          w_clear = 1'b1;
          w_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_next  = ST_IDLE;
          w_abort = 1'b1;
        end else if (w_expire) begin
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_next  = ST_IDLE;
          w_abort = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_last) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_SETTLE;
            w_load = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_table      <= '0;
      r_mis        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_clear) begin
      r_idx        <= '0;
      r_table      <= '0;
      r_mis        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_abort) begin
      r_idx <= '0;
    end else if (w_capture) begin
      r_table[r_idx] <= z_in;
      if (z_in != expected[r_idx]) begin
        r_mis <= r_mis + {{N_IN{1'b0}}, 1'b1};
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_first_fail <= r_idx;
        end
      end
      if (!w_last) begin
        r_idx <= r_idx + {{(N_IN-1){1'b0}}, 1'b1};
      end
    end
  end

  assign vec            = r_idx;
  assign busy           = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
  assign done           = (r_state == ST_DONE);
  assign table_out      = r_table;
  assign mismatch_count = r_mis;
  assign fail_valid     = r_fail_valid;
  assign first_fail     = r_first_fail;

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
// tb/tb_combo_sweep_ctrl.sv - directed self-checking bench for combo_sweep_ctrl
module tb_combo_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] expected = 32'h0;
  logic        z_in;
  logic [4:0]  vec;
  logic        busy;
  logic        done;
  logic [31:0] table_out;
  logic [5:0]  mismatch_count;
  logic        fail_valid;
  logic [4:0]  first_fail;

  logic        sel_combo = 1'b0;
  logic [31:0] golden;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic        seen_done;

  always #5 clk = ~clk;

  // stand-in for combo: z = (a & b) | (c ^ (d & e)), a = vec[4]
  assign z_in = sel_combo ? ((vec[4] & vec[3]) | (vec[2] ^ (vec[1] & vec[0]))) : vec[0];

  combo_sweep_ctrl #(.N_IN(5), .SETTLE(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .expected       (expected),
    .z_in           (z_in),
    .vec            (vec),
    .busy           (busy),
    .done           (done),
    .table_out      (table_out),
    .mismatch_count (mismatch_count),
    .fail_valid     (fail_valid),
    .first_fail     (first_fail)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      golden[i] = (v[4] & v[3]) | (v[2] ^ (v[1] & v[0]));
    end

    tick();
    // 1. reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec, 0);
    chk("rst_table", table_out, 0);
    chk("rst_mis", mismatch_count, 0);
    chk("rst_fail_valid", fail_valid, 0);
    rst = 1'b0;
    tick();

    // 2. clean sweep with z = vec[0]
    expected = 32'hAAAA_AAAA;
    do_start();
    chk("t2_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("t2_latency", cyc, 96);
    chk("t2_table", table_out, 32'hAAAA_AAAA);
    chk("t2_mis", mismatch_count, 0);
    chk("t2_fail_valid", fail_valid, 0);
    chk("t2_busy_done", busy, 0);

    // 3. two mismatching bits: 0 and 31
    expected = 32'h2AAA_AAAB;
    do_start();
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("t3_latency", cyc, 96);
    chk("t3_mis", mismatch_count, 2);
    chk("t3_fail_valid", fail_valid, 1);
    chk("t3_first_fail", first_fail, 0);

    // 4a. start while busy is ignored
    expected = 32'hAAAA_AAAA;
    do_start();
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      start = (cyc == 5) || (cyc == 50);
    end
    start = 1'b0;
    chk("t4_latency", cyc, 96);
    chk("t4_table", table_out, 32'hAAAA_AAAA);

    // 4b. abort at cycle 40: vectors 0..12 captured, partial table kept
    do_start();
    cyc = 0;
    while (cyc < 40) begin tick(); cyc++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_vec", vec, 0);
    chk("t4_abort_table", table_out, 32'h0000_0AAA);
    seen_done = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("t4_no_done", seen_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_idle_abort_busy", busy, 0);
    chk("t4_idle_abort_table", table_out, 32'h0000_0AAA);

    // 5. reset mid-sweep at vec==10
    do_start();
    cyc = 0;
    while (vec != 5'd10 && cyc < 100) begin tick(); cyc++; end
    chk("t5_reach_vec10", vec, 10);
    chk("t5_partial_table", table_out, 32'h0000_02AA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_vec", vec, 0);
    chk("t5_rst_table", table_out, 0);
    chk("t5_rst_mis", mismatch_count, 0);
    chk("t5_rst_fail", {fail_valid, first_fail}, 0);
    do_start();
    chk("t5_restart_vec", vec, 0);
    chk("t5_restart_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("t5_second_vec", vec, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // 6. combo stand-in against golden table, then restart from DONE
    sel_combo = 1'b1;
    expected  = golden;
    do_start();
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("t6_latency", cyc, 96);
    chk("t6_mis", mismatch_count, 0);
    chk("t6_table", table_out, golden);
    chk("t6_fail_valid", fail_valid, 0);
    do_start();
    chk("t6_restart_done", done, 0);
    chk("t6_restart_table", table_out, 0);
    chk("t6_restart_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
